alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: request/response ALU with single-cycle ops and an optional 32-step shift-add multiply.
// Defining ALU_SEQ_MUL_EN builds the MUL state, step counter and accumulator.

`ifndef ALU_SEQ_DEFINES_VH
`define ALU_SEQ_DEFINES_VH
`define ADD 5'd0
`define SUB 5'd1
`define LSF 5'd2
`define RSF 5'd3
`define AND 5'd4
`define OR  5'd5
`define XOR 5'd6
`define LHI 5'd7
`define LD  5'd8
`define ST  5'd9
`define MUL 5'd10
`define JLT 5'd16
`define JLE 5'd17
`define JEQ 5'd18
`define JNE 5'd19
`define JIN 5'd20
`define HLT 5'd24
`endif

module alu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  opcode,
    input  logic [31:0] alu0,
    input  logic [31:0] alu1,
    output logic [31:0] aluout,
    output logic        busy,
    output logic        done
);

    localparam int unsigned DW  = 32;
    localparam int unsigned OPW = 5;

`ifdef ALU_SEQ_MUL_EN
    localparam int unsigned CW = 6;
    localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DONE = 1'b1
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [DW-1:0]   aluout_q, aluout_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

`ifdef ALU_SEQ_MUL_EN
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   acc_q, acc_d;
`endif

    // Single-cycle result; anything not listed (including LD/ST/JIN/HLT) yields zero.
    function automatic logic [DW-1:0] alu_single(input logic [OPW-1:0] op,
                                                 input logic [DW-1:0]  a,
                                                 input logic [DW-1:0]  b);
        logic [DW-1:0] r;
        r = '0;
        case (op)
            `ADD:    r = a + b;
            `SUB:    r = a - b;
            `LSF:    r = a << b[4:0];
            `RSF:    r = DW'($signed(a) >>> b[4:0]);
            `AND:    r = a & b;
            `OR:     r = a | b;
            `XOR:    r = a ^ b;
            `LHI:    r = {b[15:0], a[15:0]};
            `JLT:    r = DW'($signed(a) <  $signed(b));
            `JLE:    r = DW'($signed(a) <= $signed(b));
            `JEQ:    r = DW'(a == b);
            `JNE:    r = DW'(a != b);
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        aluout_d = aluout_q;
`ifdef ALU_SEQ_MUL_EN
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef ALU_SEQ_MUL_EN
                    a_d = alu0;
                    b_d = alu1;
                    if (opcode == `MUL) begin
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = S_MUL;
                    end else
`endif
                    begin
                        aluout_d = alu_single(opcode, alu0, alu1);
                        state_d  = S_DONE;
                    end
                end
            end
`ifdef ALU_SEQ_MUL_EN
            // One shift-add step per cycle on multiplier bit cnt; the 32nd step finishes.
            S_MUL: begin
                acc_d = acc_q + (b_q[cnt_q[4:0]] ? (a_q << cnt_q[4:0]) : '0);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    aluout_d = acc_d;
                    state_d  = S_DONE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            aluout_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            aluout_q <= aluout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef ALU_SEQ_MUL_EN
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
`endif
        end
    end

    assign aluout = aluout_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
